ps2_rx_fifo: RTL

//   Parametrised PS/2 device-to-host receiver. Synchronises and de-glitches ps2_clk/ps2_data,

---
 rtl/ps2_rx_fifo_if.sv | 26 ++
 rtl/ps2_rx_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo_if.sv
// Host-side bundle of the PS/2 receiver: FIFO read port, occupancy and sticky error flags.
// The slave modport is the receiver; the master modport is the register block reading it.
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          rd_en;
    logic          err_clr;
    logic [7:0]    data;
    logic          valid;
    logic [CW-1:0] count;
    logic          err_parity;
    logic          err_frame;
    logic          err_overflow;

    modport master (
        output rd_en, err_clr,
        input  data, valid, count, err_parity, err_frame, err_overflow
    );

    modport slave (
        input  rd_en, err_clr,
        output data, valid, count, err_parity, err_frame, err_overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchroniser, clock de-glitch filter, 11-bit frame decoder
// with timeout, and a first-word-fall-through byte FIFO with sticky error flags.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
    logic                   r_filt, r_filt_d;
    logic [FW-1:0]          r_filt_cnt;
    logic                   w_clk_s, w_dat_s, w_strobe;

    state_t                 r_state, w_state_next;
    logic [7:0]             r_shreg;
    logic [2:0]             r_bit_cnt;
    logic                   r_parity;
    logic [TW-1:0]          r_to_cnt;
    logic                   w_timeout, w_shift, w_store_par, w_stop, w_par_ok;
    logic                   w_push_req, w_err_par_set, w_err_frm_set;

    logic [7:0]             r_mem [FIFO_DEPTH];
    logic [AW:0]            r_wr_ptr, r_rd_ptr, w_count;
    logic                   w_valid, w_full, w_pop, w_push, w_ovf_set;
    logic                   r_err_par, r_err_frm, r_err_ovf;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s  = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe = r_filt_d & ~r_filt;

    // Filtered clock only follows the synced pin after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_filt_d   <= r_filt;
            if (w_clk_s != r_filt) begin
                if (r_filt_cnt == FILT_MAX) begin
                    r_filt     <= w_clk_s;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt >= TO_MAX) && !w_strobe;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_strobe && !w_dat_s)           w_state_next = S_DATA;
            S_DATA:   if (w_strobe && r_bit_cnt == 3'd7)  w_state_next = S_PARITY;
            S_PARITY: if (w_strobe)                       w_state_next = S_STOP;
            S_STOP:   if (w_strobe)                       w_state_next = S_IDLE;
            default:                                      w_state_next = S_IDLE;
        endcase
        if (w_timeout) w_state_next = S_IDLE;
    end

    always_comb begin
        w_shift       = w_strobe && (r_state == S_DATA);
        w_store_par   = w_strobe && (r_state == S_PARITY);
        w_stop        = w_strobe && (r_state == S_STOP);
        w_par_ok      = ^{r_shreg, r_parity};
        w_push_req    = w_stop && w_par_ok && w_dat_s;
        w_err_par_set = w_stop && !w_par_ok;
        w_err_frm_set = (w_stop && !w_dat_s) || w_timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_strobe && r_state == S_IDLE) r_bit_cnt <= '0;
            if (w_shift) begin
                r_shreg[r_bit_cnt] <= w_dat_s;
                r_bit_cnt          <= r_bit_cnt + 1'b1;
            end
            if (w_store_par) r_parity <= w_dat_s;
            if (r_state == S_IDLE || w_strobe) r_to_cnt <= '0;
            else if (!w_timeout)               r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_valid   = (w_count != '0);
    assign w_full    = (w_count == FULL_CNT);
    assign w_pop     = bus.rd_en && w_valid;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovf_set = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_err_par <= w_err_par_set | (r_err_par & ~bus.err_clr);
            r_err_frm <= w_err_frm_set | (r_err_frm & ~bus.err_clr);
            r_err_ovf <= w_ovf_set     | (r_err_ovf & ~bus.err_clr);
        end
    end

    assign bus.data         = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
    assign bus.valid        = w_valid;
    assign bus.count        = w_count;
    assign bus.err_parity   = r_err_par;
    assign bus.err_frame    = r_err_frm;
    assign bus.err_overflow = r_err_ovf;
endmodule
